// File: rtl/snn_idx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_idx_pkg
// Brief    : Shared definitions for the spike-index path: constant clog2,
//            index/count width helpers and the encoder FSM state encoding.
//            Also used by the downstream weight-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package snn_idx_pkg;

  // Constant-foldable ceil(log2(value)); valid for value >= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of a popcount over a vector of the given width (0..width inclusive).
  function automatic int cnt_width(input int width);
    return clog2(width) + 1;
  endfunction

  localparam int c_DEF_WIDTH = 32;
  localparam int c_DEF_SEG_W = 16;
  localparam int c_DEF_IDX_W = clog2(c_DEF_WIDTH);
  localparam int c_DEF_CNT_W = cnt_width(c_DEF_WIDTH);

  // Encoder FSM: IDLE waits for a vector, EMIT streams its indices.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;

endpackage : snn_idx_pkg
`default_nettype wire

// File: rtl/sparse_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : sparse_prio_enc
// Brief    : Lowest-set-bit finder over WIDTH bits. The vector is split into
//            SEG_W-bit segments, each with its own small priority encoder;
//            a second encoder picks the lowest non-empty segment. Returns the
//            bit index, a found flag and a one-hot mask of that bit.
// Revision : 1.0 - initial release
// ============================================================================
module sparse_prio_enc
  import snn_idx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16,
  parameter int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o,
  output logic [WIDTH-1:0] clr_mask_o
);

  localparam int c_NSEG      = WIDTH / SEG_W;
  localparam int c_SEG_IDX_W = clog2(SEG_W);
  localparam int c_SEL_W     = (c_NSEG > 1) ? clog2(c_NSEG) : 1;

  logic                   w_seg_found [c_NSEG];
  logic [c_SEG_IDX_W-1:0] w_seg_idx   [c_NSEG];
  logic [c_SEL_W-1:0]     w_sel;
  logic [c_SEG_IDX_W-1:0] w_low;
  logic                   w_any;

  for (genvar s = 0; s < c_NSEG; s++) begin : g_seg
    logic [SEG_W-1:0]       w_bits;
    logic                   w_found;
    logic [c_SEG_IDX_W-1:0] w_idx;

    assign w_bits = vec_i[s*SEG_W +: SEG_W];

    // Segment-local priority encoder: scan downwards so the lowest hit wins.
    always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int b = SEG_W - 1; b >= 0; b--) begin
        if (w_bits[b]) begin
          w_found = 1'b1;
          w_idx   = c_SEG_IDX_W'(b);
        end
      end
    end

    assign w_seg_found[s] = w_found;
    assign w_seg_idx[s]   = w_idx;
  end

  // Segment-select encoder: lowest segment holding a set bit.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_low = '0;
    for (int s = c_NSEG - 1; s >= 0; s--) begin
      if (w_seg_found[s]) begin
        w_any = 1'b1;
        w_sel = c_SEL_W'(s);
        w_low = w_seg_idx[s];
      end
    end
  end

  if (c_NSEG == 1) begin : g_one_seg
    assign idx_o = w_low;
  end else begin : g_multi_seg
    assign idx_o = {w_sel, w_low};
  end

  assign found_o = w_any;

  // One-hot mask of the located bit, used by the caller to retire it.
  always_comb begin
    clr_mask_o        = '0;
    clr_mask_o[idx_o] = w_any;
  end

endmodule : sparse_prio_enc
`default_nettype wire

// File: rtl/sparse_idx_enc.sv
`default_nettype none
// ============================================================================
// Module   : sparse_idx_enc
// Brief    : Sparse spike-vector to index-stream encoder. Accepts one WIDTH-bit
//            vector per handshake and emits the index of every set bit, lowest
//            first, one per beat, with opt_last/opt_empty frame markers and
//            back-to-back vector acceptance on the final beat.
// Config   : SPARSE_IDX_CNT_EN - when defined, adds the opt_cnt port carrying
//            the popcount of the current vector on every beat of its frame.
// Revision : 1.0 - initial release
// ============================================================================
module sparse_idx_enc
  import snn_idx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = clog2(WIDTH),  // derived, do not override
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ipt_valid,
  output logic             ipt_ready,
  input  logic [WIDTH-1:0] sparse_bits,
  output logic             opt_valid,
  input  logic             opt_ready,
  output logic [IDX_W-1:0] enc,
  output logic             opt_last,
  output logic             opt_empty
`ifdef SPARSE_IDX_CNT_EN
  ,
  output logic [IDX_W:0]   opt_cnt
`endif
);

  enc_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // bits still to emit after the current beat
  logic [IDX_W-1:0] enc_q, enc_d;
  logic             last_q, last_d;
  logic             empty_q, empty_d;

  logic             w_accept;
  logic             w_advance;
  logic             w_retire;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_rest;
  logic [WIDTH-1:0] w_mask;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // A new vector is taken when idle, or when the final beat of the current
  // frame leaves this cycle; only registered state and opt_ready matter.
  assign ipt_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_EMIT) && last_q && opt_ready);
  assign w_accept  = ipt_valid && ipt_ready;
  assign w_advance = (state_q == ST_EMIT) && opt_ready && !last_q;
  assign w_retire  = (state_q == ST_EMIT) && opt_ready && last_q && !w_accept;

  // The encoder looks at the incoming vector on accept, else at the residue,
  // so the first index is registered in the same cycle as the handshake.
  assign w_src  = w_accept ? sparse_bits : rem_q;
  assign w_rest = w_src & ~w_mask;

  sparse_prio_enc #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec_i      (w_src),
    .idx_o      (w_idx),
    .found_o    (w_found),
    .clr_mask_o (w_mask)
  );

  // Next-state and next-beat logic; everything holds unless a beat moves.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    enc_d   = enc_q;
    last_d  = last_q;
    empty_d = empty_q;
    if (w_accept || w_advance) begin
      state_d = ST_EMIT;
      rem_d   = w_rest;
      enc_d   = w_found ? w_idx : '0;
      last_d  = (w_rest == '0);
      empty_d = !w_found;
    end else if (w_retire) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      enc_d   = '0;
      last_d  = 1'b0;
      empty_d = 1'b0;
    end
  end

  // State, residue and output beat registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      enc_q   <= '0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      enc_q   <= enc_d;
      last_q  <= last_d;
      empty_q <= empty_d;
    end
  end

  assign opt_valid = (state_q == ST_EMIT);
  assign enc       = enc_q;
  assign opt_last  = last_q;
  assign opt_empty = empty_q;

`ifdef SPARSE_IDX_CNT_EN
  logic [IDX_W:0] cnt_q, cnt_d;
  logic [IDX_W:0] w_pop;

  // Popcount of the incoming vector; only consumed on accept.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + (IDX_W+1)'(sparse_bits[i]);
    end
  end

  // Count is captured at accept and held for the whole frame.
  always_comb begin
    cnt_d = cnt_q;
    if (w_accept) begin
      cnt_d = w_pop;
    end else if (w_retire) begin
      cnt_d = '0;
    end
  end

  // Frame popcount register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign opt_cnt = cnt_q;
`endif

endmodule : sparse_idx_enc
`default_nettype wire

// File: tb/tb_sparse_idx_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sparse_idx_enc
// Brief    : Self-checking bench for sparse_idx_enc (WIDTH=32, SEG_W=16).
//            A frame-level model expands each accepted vector into its list
//            of beats; every cycle the DUT outputs are compared against it.
// Config   : SPARSE_IDX_CNT_EN - also checks opt_cnt when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparse_idx_enc;

  localparam int WIDTH = 32;
  localparam int SEG_W = 16;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ipt_valid = 1'b0;
  logic             ipt_ready;
  logic [WIDTH-1:0] sparse_bits = '0;
  logic             opt_valid;
  logic             opt_ready = 1'b1;
  logic [IDX_W-1:0] enc;
  logic             opt_last;
  logic             opt_empty;
  logic [IDX_W:0]   cnt_obs;

`ifdef SPARSE_IDX_CNT_EN
  logic [IDX_W:0] opt_cnt;
  assign cnt_obs = opt_cnt;
`else
  assign cnt_obs = '0;
`endif

  sparse_idx_enc #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ipt_valid   (ipt_valid),
    .ipt_ready   (ipt_ready),
    .sparse_bits (sparse_bits),
    .opt_valid   (opt_valid),
    .opt_ready   (opt_ready),
    .enc         (enc),
    .opt_last    (opt_last),
    .opt_empty   (opt_empty)
`ifdef SPARSE_IDX_CNT_EN
    ,
    .opt_cnt     (opt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit empty;
    int cnt;
  } beat_t;

  beat_t q[$];        // expected beats not yet consumed
  beat_t log_q[$];    // beats observed leaving the DUT
  int    log_cyc[$];
  int    cyc = 0;
  int    acc_cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  bit    rand_en = 1'b0;
  bit    exp_rdy;
  beat_t ob;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expand a vector into the beats it must produce.
  function automatic void model_push(input logic [31:0] v);
    int    pc;
    int    seen;
    beat_t b;
    pc   = 0;
    seen = 0;
    for (int i = 0; i < 32; i++) pc += int'(v[i]);
    if (pc == 0) begin
      b.idx = 0; b.last = 1'b1; b.empty = 1'b1; b.cnt = 0;
      q.push_back(b);
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (v[i]) begin
          seen++;
          b.idx = i; b.last = (seen == pc); b.empty = 1'b0; b.cnt = pc;
          q.push_back(b);
        end
      end
    end
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        q.delete();
      end else begin
        check("opt_valid", opt_valid, q.size() != 0);
        if (q.size() != 0) begin
          check("enc", enc, q[0].idx);
          check("opt_last", opt_last, q[0].last);
          check("opt_empty", opt_empty, q[0].empty);
`ifdef SPARSE_IDX_CNT_EN
          check("opt_cnt", cnt_obs, q[0].cnt);
`endif
          exp_rdy = q[0].last && opt_ready;
        end else begin
          exp_rdy = 1'b1;
        end
        check("ipt_ready", ipt_ready, exp_rdy);
        if (opt_valid && opt_ready && q.size() != 0) begin
          ob.idx = int'(enc); ob.last = opt_last; ob.empty = opt_empty; ob.cnt = int'(cnt_obs);
          log_q.push_back(ob);
          log_cyc.push_back(cyc);
          void'(q.pop_front());
        end
        if (ipt_valid && ipt_ready) model_push(sparse_bits);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_en) opt_ready = ($urandom_range(0, 99) < 80);
  endtask

  task automatic send(input logic [31:0] v);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    ipt_valid   = 1'b1;
    sparse_bits = v;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc     = ipt_ready;
      acc_cyc = cyc;
      step();
      n++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no ipt_ready expected handshake for %h", v);
    end
    ipt_valid   = 1'b0;
    sparse_bits = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || opt_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got %0d beats pending expected 0", q.size());
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with upstream valid and downstream ready both asserted.
    ipt_valid   = 1'b1;
    sparse_bits = 32'hDEAD_BEEF;
    opt_ready   = 1'b1;
    rst         = 1'b1;
    @(posedge clk); #1;
    check("rst_ipt_ready", ipt_ready, 1);
    check("rst_opt_valid", opt_valid, 0);
    check("rst_enc", enc, 0);
    check("rst_opt_last", opt_last, 0);
    check("rst_opt_empty", opt_empty, 0);
    check("rst_opt_cnt", cnt_obs, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_opt_valid", opt_valid, 0);
    ipt_valid = 1'b0;
    rst       = 1'b0;
    chk_en    = 1'b1;
    step();
    check("post_rst_ipt_ready", ipt_ready, 1);
    check("post_rst_opt_valid", opt_valid, 0);

    // Three set bits, downstream always ready.
    clear_log();
    send(32'h8000_0011);
    wait_idle(100);
    check("t2_nbeats", log_q.size(), 3);
    check("t2_enc0", log_q[0].idx, 0);
    check("t2_enc1", log_q[1].idx, 4);
    check("t2_enc2", log_q[2].idx, 31);
    check("t2_last1", log_q[1].last, 0);
    check("t2_last2", log_q[2].last, 1);
    check("t2_latency", log_cyc[0] - acc_cyc, 1);
    check("t2_span", log_cyc[2] - log_cyc[0], 2);

    // Empty vector: one marker beat.
    clear_log();
    send(32'h0);
    wait_idle(100);
    check("t3_nbeats", log_q.size(), 1);
    check("t3_enc", log_q[0].idx, 0);
    check("t3_empty", log_q[0].empty, 1);
    check("t3_last", log_q[0].last, 1);
    check("t3_ipt_ready", ipt_ready, 1);

    // Back-to-back vectors with no bubble between frames.
    clear_log();
    send(32'h0000_0006);
    send(32'h0001_0000);
    wait_idle(100);
    check("t4_nbeats", log_q.size(), 3);
    check("t4_enc0", log_q[0].idx, 1);
    check("t4_enc1", log_q[1].idx, 2);
    check("t4_enc2", log_q[2].idx, 16);
    check("t4_last1", log_q[1].last, 1);
    check("t4_span", log_cyc[2] - log_cyc[0], 2);

    // All ones with a randomly stalling consumer.
    clear_log();
    rand_en = 1'b1;
    send(32'hFFFF_FFFF);
    wait_idle(2000);
    rand_en   = 1'b0;
    opt_ready = 1'b1;
    check("t5_nbeats", log_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      if (i < log_q.size()) check($sformatf("t5_enc%0d", i), log_q[i].idx, i);
    end
    check("t5_last31", log_q[31].last, 1);
    check("t5_last30", log_q[30].last, 0);
`ifdef SPARSE_IDX_CNT_EN
    check("t5_cnt", log_q[31].cnt, 32);
`endif

    // Reset in the middle of a frame drops the remainder.
    clear_log();
    send(32'h0000_00F0);
    step();
    step();
    rst = 1'b1;
    step();
    check("t6_valid_after_rst", opt_valid, 0);
    rst = 1'b0;
    repeat (5) step();
    check("t6_nbeats", log_q.size(), 2);
    check("t6_enc0", log_q[0].idx, 4);
    check("t6_enc1", log_q[1].idx, 5);
    check("t6_valid_idle", opt_valid, 0);
    check("t6_ipt_ready", ipt_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sparse_idx_enc
`default_nettype wire
